// File: rtl/idelay_ctrl_pkg.sv
// Shared FSM state type and lane-index width helper for the IDELAY multi-lane controller.
package idelay_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_CHK    = 2'd0,
        ST_CALC   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/idelay_step_calc.sv
// Combinational tap-step clamp: moves cur toward tgt by at most MAX_STEP taps
// (MAX_STEP == 0 jumps straight to tgt).
module idelay_step_calc #(
    parameter int CNT_W    = 9,
    parameter int MAX_STEP = 8
) (
    input  logic [CNT_W-1:0] cur,
    input  logic [CNT_W-1:0] tgt,
    output logic [CNT_W-1:0] next_val
);

    localparam logic signed [CNT_W+1:0] LIM  = (CNT_W+2)'(MAX_STEP);
    localparam logic        [CNT_W-1:0] STEP = CNT_W'(MAX_STEP);

    logic signed [CNT_W+1:0] diff;

    // Within the limit cur+diff is simply tgt; clamped steps never overshoot, so no wrap.
    always_comb begin
        diff     = signed'({2'b00, tgt}) - signed'({2'b00, cur});
        next_val = tgt;
        if ((MAX_STEP != 0) && ((diff >= LIM) || (diff <= -LIM))) begin
            if (!diff[CNT_W+1]) begin
                next_val = cur + STEP;
            end else begin
                next_val = cur - STEP;
            end
        end
    end

endmodule

// File: rtl/idelay_multi_set_ctrl.sv
// Round-robin IDELAY tap controller: one FSM steps N_CH lanes toward their targets.
// Optional readback check of each write is enabled by defining IDELAY_READBACK_CHK_EN.
module idelay_multi_set_ctrl
    import idelay_ctrl_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 9,
    parameter int MAX_STEP      = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      clk160,
    input  logic                      rstb,
    input  logic [N_CH*CNT_W-1:0]     delay_target,
    input  logic [N_CH*CNT_W-1:0]     delay_out,
    output logic [N_CH*CNT_W-1:0]     delay_set_value,
    output logic [N_CH-1:0]           delay_wr,
    output logic [N_CH-1:0]           delay_ready,
    output logic                      all_ready,
    output logic [idx_w(N_CH)-1:0]    active_ch,
    output logic [N_CH-1:0]           wr_mismatch
);

    localparam int LANE_W = idx_w(N_CH);
    localparam int SCNT_W = idx_w(SETTLE_CYCLES);
    localparam logic [LANE_W-1:0] LAST_CH     = LANE_W'(N_CH - 1);
    localparam logic [SCNT_W-1:0] LAST_SETTLE = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_CH-1:0]   LANE0_BIT   = N_CH'(1);

    state_t              state;
    logic [LANE_W-1:0]   ch;
    logic [LANE_W-1:0]   ch_next;
    logic [SCNT_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]    cur;
    logic [CNT_W-1:0]    tgt;
    logic [CNT_W-1:0]    out_sel;
    logic [CNT_W-1:0]    tgt_sel;
    logic [CNT_W-1:0]    next_val;
    logic                lane_eq;
    logic [N_CH-1:0]     ready_upd;

    always_comb begin
        out_sel       = delay_out[ch*CNT_W +: CNT_W];
        tgt_sel       = delay_target[ch*CNT_W +: CNT_W];
        lane_eq       = (out_sel == tgt_sel);
        ch_next       = (ch == LAST_CH) ? '0 : ch + 1'b1;
        ready_upd     = delay_ready;
        ready_upd[ch] = lane_eq;
    end

    idelay_step_calc #(
        .CNT_W    (CNT_W),
        .MAX_STEP (MAX_STEP)
    ) u_step_calc (
        .cur      (cur),
        .tgt      (tgt),
        .next_val (next_val)
    );

    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            state           <= ST_CHK;
            ch              <= '0;
            settle_cnt      <= '0;
            cur             <= '0;
            tgt             <= '0;
            delay_set_value <= '0;
            delay_wr        <= '0;
            delay_ready     <= '0;
            all_ready       <= 1'b0;
        end else begin
            delay_wr <= '0;
            case (state)
                ST_CHK: begin
                    cur         <= out_sel;
                    tgt         <= tgt_sel;
                    delay_ready <= ready_upd;
                    all_ready   <= &ready_upd;
                    if (lane_eq) begin
                        ch <= ch_next;
                    end else begin
                        state <= ST_CALC;
                    end
                end
                // Strobe is registered here so it is high exactly during WRITE.
                ST_CALC: begin
                    delay_set_value[ch*CNT_W +: CNT_W] <= next_val;
                    delay_wr <= LANE0_BIT << ch;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        settle_cnt <= '0;
                        ch         <= ch_next;
                        state      <= ST_CHK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= ST_CHK;
            endcase
        end
    end

    assign active_ch = ch;

`ifdef IDELAY_READBACK_CHK_EN
    logic            settle_last;
    logic [N_CH-1:0] mismatch;

    assign settle_last = (state == ST_SETTLE) && (settle_cnt == LAST_SETTLE);

    // Sticky until reset: a lane that once failed to take its value stays flagged.
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            mismatch <= '0;
        end else if (settle_last && (out_sel != delay_set_value[ch*CNT_W +: CNT_W])) begin
            mismatch[ch] <= 1'b1;
        end
    end

    assign wr_mismatch = mismatch;
`else
    assign wr_mismatch = '0;
`endif

endmodule

// File: tb/tb_idelay_multi_set_ctrl.sv
// Directed bench for idelay_multi_set_ctrl with a register model of each IDELAY lane.
module tb_idelay_multi_set_ctrl;

    localparam int N_CH  = 4;
    localparam int CNT_W = 9;
    localparam int W     = N_CH * CNT_W;

`ifdef IDELAY_READBACK_CHK_EN
    localparam logic [N_CH-1:0] EXP_MM = 4'b0010;
`else
    localparam logic [N_CH-1:0] EXP_MM = 4'b0000;
`endif

    logic clk160 = 1'b0;
    logic rstb   = 1'b0;
    always #5 clk160 = ~clk160;

    logic [W-1:0]    target, model, preload, set_value;
    logic [N_CH-1:0] wr, ready, mism;
    logic            all_ready;
    logic [1:0]      active_ch;
    logic            ignore_l1;

    logic [W-1:0]    target_j, model_j, set_value_j;
    logic [N_CH-1:0] wr_j, ready_j, mism_j;
    logic            all_ready_j;
    logic [1:0]      active_ch_j;

    idelay_multi_set_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .MAX_STEP(8), .SETTLE_CYCLES(4)
    ) dut (
        .clk160          (clk160),
        .rstb            (rstb),
        .delay_target    (target),
        .delay_out       (model),
        .delay_set_value (set_value),
        .delay_wr        (wr),
        .delay_ready     (ready),
        .all_ready       (all_ready),
        .active_ch       (active_ch),
        .wr_mismatch     (mism)
    );

    idelay_multi_set_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .MAX_STEP(0), .SETTLE_CYCLES(4)
    ) dut_j (
        .clk160          (clk160),
        .rstb            (rstb),
        .delay_target    (target_j),
        .delay_out       (model_j),
        .delay_set_value (set_value_j),
        .delay_wr        (wr_j),
        .delay_ready     (ready_j),
        .all_ready       (all_ready_j),
        .active_ch       (active_ch_j),
        .wr_mismatch     (mism_j)
    );

    // IDELAY models: preset while in reset, loaded on the write strobe otherwise.
    always @(posedge clk160) begin
        for (int k = 0; k < N_CH; k++) begin
            if (!rstb) begin
                model[k*CNT_W +: CNT_W]   <= preload[k*CNT_W +: CNT_W];
                model_j[k*CNT_W +: CNT_W] <= '0;
            end else begin
                if (wr[k] && !(ignore_l1 && (k == 1)))
                    model[k*CNT_W +: CNT_W] <= set_value[k*CNT_W +: CNT_W];
                if (wr_j[k])
                    model_j[k*CNT_W +: CNT_W] <= set_value_j[k*CNT_W +: CNT_W];
            end
        end
    end

    logic [N_CH-1:0]  log_vec[$];
    logic [CNT_W-1:0] log_val[$];

    always @(negedge clk160) begin
        for (int k = 0; k < N_CH; k++) begin
            if (wr[k]) begin
                log_vec.push_back(wr);
                log_val.push_back(set_value[k*CNT_W +: CNT_W]);
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int base;
    int n;
    bit ok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] lane(input logic [W-1:0] v, input int k);
        return v[k*CNT_W +: CNT_W];
    endfunction

    function automatic logic [63:0] log_val_at(input int i);
        return (i < log_val.size()) ? 64'(log_val[i]) : 64'hx;
    endfunction

    function automatic logic [63:0] log_vec_at(input int i);
        return (i < log_vec.size()) ? 64'(log_vec[i]) : 64'hx;
    endfunction

    initial begin
        ignore_l1 = 1'b0;
        target    = '0;
        preload   = '0;
        target_j  = {9'd0, 9'd0, 9'd300, 9'd0};
        repeat (3) @(negedge clk160);

        chk("rst_set_value", 64'(set_value), 64'd0);
        chk("rst_wr",        64'(wr),        64'd0);
        chk("rst_ready",     64'(ready),     64'd0);
        chk("rst_all_ready", 64'(all_ready), 64'd0);
        chk("rst_active_ch", 64'(active_ch), 64'd0);
        chk("rst_mismatch",  64'(mism),      64'd0);

        // Lane 0 ramps 0 -> 20 in steps of 8
        target = {9'd0, 9'd0, 9'd0, 9'd20};
        base   = log_vec.size();
        rstb   = 1'b1;
        repeat (80) @(negedge clk160);
        chk("t1_nwr",   64'(log_vec.size() - base), 64'd3);
        chk("t1_vec0",  log_vec_at(base),     64'b0001);
        chk("t1_val0",  log_val_at(base),     64'd8);
        chk("t1_vec1",  log_vec_at(base + 1), 64'b0001);
        chk("t1_val1",  log_val_at(base + 1), 64'd16);
        chk("t1_vec2",  log_vec_at(base + 2), 64'b0001);
        chk("t1_val2",  log_val_at(base + 2), 64'd20);
        chk("t1_all_ready", 64'(all_ready), 64'd1);
        chk("t1_ready",     64'(ready),     64'hf);
        chk("t1_mismatch",  64'(mism),      64'd0);

        // Lane 2 settled at 100, then retargeted to 93
        rstb    = 1'b0;
        preload = {9'd0, 9'd100, 9'd0, 9'd0};
        target  = {9'd0, 9'd100, 9'd0, 9'd0};
        repeat (3) @(negedge clk160);
        base = log_vec.size();
        rstb = 1'b1;
        repeat (20) @(negedge clk160);
        chk("t2_idle_nwr", 64'(log_vec.size() - base), 64'd0);
        chk("t2_ready_pre", 64'(ready), 64'hf);
        target = {9'd0, 9'd93, 9'd0, 9'd0};
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk160);
            if (|wr) ok = 1'b1;
        end
        chk("t2_wr_seen",     64'(ok),                64'd1);
        chk("t2_wr_vec",      64'(wr),                64'b0100);
        chk("t2_wr_val",      64'(lane(set_value, 2)), 64'd93);
        chk("t2_ready_at_wr", 64'(ready),             64'b1011);
        repeat (20) @(negedge clk160);
        chk("t2_ready_post", 64'(ready), 64'hf);
        chk("t2_nwr", 64'(log_vec.size() - base), 64'd1);

        // Unlimited step: lane 1 jumps 0 -> 300, then 1+SETTLE cycles to next CHK
        rstb = 1'b0;
        repeat (3) @(negedge clk160);
        rstb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk160);
            if (|wr_j) ok = 1'b1;
        end
        chk("t3_wr_seen", 64'(ok),                   64'd1);
        chk("t3_wr_vec",  64'(wr_j),                 64'b0010);
        chk("t3_wr_val",  64'(lane(set_value_j, 1)), 64'd300);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk160);
            n++;
            if (active_ch_j == 2'd2) ok = 1'b1;
        end
        chk("t3_gap", 64'(n), 64'd5);
        repeat (20) @(negedge clk160);
        chk("t3_ready", 64'(ready_j), 64'hf);

        // Everything at target: pure 1-cycle skips, no writes
        rstb    = 1'b0;
        preload = {9'd8, 9'd7, 9'd6, 9'd5};
        target  = {9'd8, 9'd7, 9'd6, 9'd5};
        repeat (3) @(negedge clk160);
        base = log_vec.size();
        rstb = 1'b1;
        chk("t4_ch0", 64'(active_ch), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk160);
            chk($sformatf("t4_ch_step%0d", i), 64'(active_ch), 64'(i % 4));
        end
        repeat (40) @(negedge clk160);
        chk("t4_nwr", 64'(log_vec.size() - base), 64'd0);
        chk("t4_all_ready", 64'(all_ready), 64'd1);

        // Reset during lane 3 SETTLE, then resume from lane 0
        rstb    = 1'b0;
        preload = '0;
        target  = {9'd50, 9'd0, 9'd0, 9'd0};
        repeat (3) @(negedge clk160);
        rstb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk160);
            if (wr == 4'b1000) ok = 1'b1;
        end
        chk("t5_wr_seen", 64'(ok), 64'd1);
        repeat (2) @(negedge clk160);
        #2 rstb = 1'b0;
        #1;
        chk("t5_rst_set_value", 64'(set_value), 64'd0);
        chk("t5_rst_wr",        64'(wr),        64'd0);
        chk("t5_rst_active_ch", 64'(active_ch), 64'd0);
        chk("t5_rst_ready",     64'(ready),     64'd0);
        chk("t5_rst_all_ready", 64'(all_ready), 64'd0);
        preload = {9'd8, 9'd0, 9'd0, 9'd0};
        repeat (3) @(negedge clk160);
        rstb = 1'b1;
        chk("t5_resume_ch", 64'(active_ch), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk160);
            chk($sformatf("t5_nowr%0d", i), 64'(wr), 64'd0);
        end
        @(negedge clk160);
        chk("t5_wr_vec", 64'(wr),                 64'b1000);
        chk("t5_wr_val", 64'(lane(set_value, 3)), 64'd16);

        // Lane 1 ignores its write: readback flag (when built) is set and sticky
        rstb      = 1'b0;
        preload   = '0;
        target    = {9'd0, 9'd0, 9'd5, 9'd0};
        ignore_l1 = 1'b1;
        repeat (3) @(negedge clk160);
        rstb = 1'b1;
        repeat (30) @(negedge clk160);
        chk("t6_mismatch", 64'(mism), 64'(EXP_MM));
        ignore_l1 = 1'b0;
        repeat (40) @(negedge clk160);
        chk("t6_sticky", 64'(mism),  64'(EXP_MM));
        chk("t6_ready",  64'(ready), 64'hf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/idelay_multi_set_ctrl.md
Name: idelay_multi_set_ctrl

Overview:
Multi-channel, parametrised successor to the single-lane IDELAY step controller. One time-shared FSM services N_CH IDELAY count ports in round-robin order. Each visit moves a lane's tap count toward its target by at most MAX_STEP taps, then waits a settle period before the next lane. Sits between the delay-scan/config registers and the IDELAYE3 CNTVALUEIN/LOAD ports of an ISERDES receive bank.

Parameters:
N_CH, 4, number of delay lanes serviced (1..32)
CNT_W, 9, tap count width per lane
MAX_STEP, 8, largest per-write tap change; 0 = unlimited (jump straight to target)
SETTLE_CYCLES, 4, idle cycles after each write before next lane visit (>=1)

Ports:
clk160  in  1  fabric clock; all logic on rising edge
rstb  in  1  asynchronous, active-low reset
delay_target  in  N_CH*CNT_W  requested tap count; lane k at [k*CNT_W +: CNT_W]
delay_out  in  N_CH*CNT_W  current tap count read back from IDELAY (CNTVALUEOUT)
delay_set_value  out  N_CH*CNT_W  per-lane value driven to CNTVALUEIN; held between writes
delay_wr  out  N_CH  one-hot, one-cycle load strobe per lane
delay_ready  out  N_CH  lane k: delay_out == delay_target at its last check
all_ready  out  1  AND of delay_ready
active_ch  out  $clog2(N_CH) (min 1)  lane index currently being serviced
wr_mismatch  out  N_CH  sticky readback error flags (see Optional Feature)

Behaviour:
- Reset (rstb low, async): state CHK, active_ch=0, delay_set_value=0, delay_wr=0, delay_ready=0, all_ready=0, wr_mismatch=0, settle counter=0. Reset mid-write aborts without completing the write.
- States: CHK, CALC, WRITE, SETTLE.
- CHK (1 cycle): capture cur=delay_out[ch], tgt=delay_target[ch]; delay_ready[ch] <= (cur==tgt). If equal, advance to next lane, next state CHK (skipped lane costs 1 cycle). Else -> CALC.
- CALC (1 cycle): diff = tgt - cur as signed CNT_W+1. If MAX_STEP==0, or -MAX_STEP < diff < MAX_STEP, step=diff. Otherwise step = +MAX_STEP when diff>0, else -MAX_STEP. delay_set_value[ch] <= cur+step, truncated to CNT_W; no wrap, since the step never overshoots the target. -> WRITE.
- WRITE (1 cycle): delay_wr[ch]=1. All other bits are 0 and delay_set_value is stable this cycle. -> SETTLE.
- SETTLE: count SETTLE_CYCLES cycles. On the last one, advance the lane and go to CHK.
- Lane advance: ch = (ch==N_CH-1) ? 0 : ch+1.
- Full non-skip visit = 3 + SETTLE_CYCLES cycles.
- Target and readback values are sampled only in CHK. A target change during CALC/WRITE/SETTLE takes effect on the lane's next visit. delay_ready of a lane may therefore lag its target by up to one round.
- delay_ready[ch] updates only in CHK of that lane. all_ready is registered, updated the same cycle.
- Other lanes' delay_set_value bits never change while a different lane is serviced.
- N_CH==1 degenerates to a single lane with active_ch tied 0.

Optional Feature:
IDELAY_READBACK_CHK_EN
- Defined: on the last SETTLE cycle, compare delay_out[ch] with delay_set_value[ch]. On mismatch, set wr_mismatch[ch]; it stays set until rstb.
- Undefined: wr_mismatch is tied to 0 and no comparator is built. FSM timing is identical either way.

Decomposition:
- Package idelay_ctrl_pkg: state enum (CHK/CALC/WRITE/SETTLE), state width localparam, and clog2-based lane-index width helper.
- Sub-module idelay_step_calc: combinational clamp taking (cur, tgt, MAX_STEP) and producing next set value. Reusable and unit-testable on its own.

Test Plan:
- Bench models each IDELAY as a register loaded from delay_set_value on delay_wr; defaults apply unless stated.
- Lane 0 target 20, others 0, reset counts 0 -> lane 0 writes 8, 16, 20 on three successive visits of lane 0. Lanes 1-3 never write. Then all_ready=1.
- Target 100 -> 93 on lane 2 -> single write of 93. delay_ready[2] is 0 before the write and 1 at the next lane-2 CHK.
- MAX_STEP=0, lane 1 target 300 from 0 -> one write of 300. Write-to-next-CHK gap is exactly 1+SETTLE_CYCLES cycles.
- All lanes already at target -> no delay_wr ever. active_ch cycles 0,1,2,3,0 one per clock.
- Assert rstb during lane 3 SETTLE -> outputs 0 immediately. After release, servicing resumes at lane 0 with no spurious delay_wr.
- IDELAY_READBACK_CHK_EN defined, model ignores one lane-1 write -> wr_mismatch[1]=1 and sticky, other bits 0. Macro undefined -> wr_mismatch stays 0.
